// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: computes results at acceptance, holds them in
// pending registers, and commits HI/LO after a fixed busy latency.
module mdu_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    input  logic        rd_hi,
    output logic        busy,
    output logic        stall,
    output logic [31:0] Out
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_div_zero;
    logic        w_accept;
    logic        w_commit;
    logic        w_long_req;
    logic [63:0] w_mul_res;
    logic [63:0] w_div_res;

    // 64-bit product; signed operands are sign-extended before multiplying.
    function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            sp = sa * sb;
            return sp;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes, so
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic        neg_q;
        logic        neg_r;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        neg_r = sgn & a[31];
        neg_q = sgn & (a[31] ^ b[31]);
        ma    = neg_r ? -a : a;
        mb    = (sgn & b[31]) ? -b : b;
        if (mb == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (neg_q) q = -q;
        if (neg_r) r = -r;
        return {r, q};
    endfunction

    assign w_mul_res  = f_mul(A, B, mdu_op == OP_MULT);
    assign w_div_res  = f_div(A, B, mdu_op == OP_DIV);
    assign w_long_req = start & ~flush & (mdu_op >= OP_MULT) & (mdu_op <= OP_DIVU);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        w_accept    = (r_state == IDLE) & start & ~flush &
                      (mdu_op >= OP_MULT) & (mdu_op <= OP_MTLO);
        case (r_state)
            IDLE: begin
                if (w_accept && (mdu_op == OP_MULT || mdu_op == OP_MULTU)) begin
                    w_state_nxt = MUL_RUN;
                    w_cnt_nxt   = 4'(MUL_CYCLES);
                end else if (w_accept && (mdu_op == OP_DIV || mdu_op == OP_DIVU)) begin
                    w_state_nxt = DIV_RUN;
                    w_cnt_nxt   = 4'(DIV_CYCLES);
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_pend_hi  <= 32'd0;
            r_pend_lo  <= 32'd0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            case (mdu_op)
                OP_MULT, OP_MULTU: begin
                    r_pend_hi  <= w_mul_res[63:32];
                    r_pend_lo  <= w_mul_res[31:0];
                    r_div_zero <= 1'b0;
                end
                OP_DIV, OP_DIVU: begin
                    r_pend_hi  <= w_div_res[63:32];
                    r_pend_lo  <= w_div_res[31:0];
                    r_div_zero <= (B == 32'd0);
                end
                OP_MTHI: r_hi <= A;
                OP_MTLO: r_lo <= A;
                default: ;
            endcase
        end else if (w_commit && !r_div_zero) begin
            // A divide by zero runs full length but leaves HI/LO untouched.
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
        end
    end

    assign busy  = (r_state != IDLE);
    assign stall = busy | w_long_req;
    assign Out   = rd_hi ? r_hi : r_lo;

endmodule
